// File: rtl/nock_dispatch_ctrl_pkg.sv
// rtl/nock_dispatch_ctrl_pkg.sv - shared widths, control-mux select codes and dispatch FSM encodings
//
// Purpose: single source for the memory address/data widths, the MUX_* select codes
// used by the shared control mux, and the 3-bit dispatch state encodings.
// Ports: none (package).

package nock_dispatch_ctrl_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 64;

    localparam logic [2:0] MUX_TRAVERSAL = 3'd0;
    localparam logic [2:0] MUX_EXECUTE   = 3'd1;
    localparam logic [2:0] MUX_CELL      = 3'd2;
    localparam logic [2:0] MUX_INCR      = 3'd3;
    localparam logic [2:0] MUX_EQUAL     = 3'd4;
    localparam logic [2:0] MUX_EDIT      = 3'd5;

    localparam logic [2:0] DISPATCH_IDLE    = 3'd0;
    localparam logic [2:0] DISPATCH_LAUNCH  = 3'd1;
    localparam logic [2:0] DISPATCH_WAIT    = 3'd2;
    localparam logic [2:0] DISPATCH_RELEASE = 3'd3;
    localparam logic [2:0] DISPATCH_RESPOND = 3'd4;

    typedef struct packed {
        logic [3:0] sys_func;
        logic [3:0] state;
        logic       error;
    } done_resp_t;

    // Only the five opcode submodules are legal dispatch targets.
    function automatic logic is_module_sel(input logic [2:0] code);
        return (code >= MUX_EXECUTE) && (code <= MUX_EDIT);
    endfunction

endpackage

// File: rtl/nock_dispatch_ctrl.sv
// rtl/nock_dispatch_ctrl.sv - hands the shared module address/data path from traversal to one opcode submodule and back
//
// Purpose: accepts one dispatch request from traversal, drives the control-mux select,
// pulses module_start, waits for finished, releases the mux back to traversal and
// presents the captured return_sys_func/return_state until traversal accepts it.
// Optional macro: DISPATCH_TIMEOUT_EN adds a WAIT-state timeout (TIMEOUT_CYCLES).
// Ports:
//   clk, rst (async, active-low)
//   req_valid/req_ready/req_sel/req_address/req_data   dispatch request from traversal
//   sel, module_start, module_address, module_data      control mux and submodule drive
//   finished, return_sys_func, return_state             muxed submodule completion
//   done_valid/done_ready/done_sys_func/done_state/done_error   response to traversal
//   busy                                                state != IDLE

module nock_dispatch_ctrl
    import nock_dispatch_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int TIMEOUT_W      = 13
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [2:0]        req_sel,
    input  logic [ADDR_W-1:0] req_address,
    input  logic [DATA_W-1:0] req_data,
    output logic [2:0]        sel,
    output logic              module_start,
    output logic [ADDR_W-1:0] module_address,
    output logic [DATA_W-1:0] module_data,
    input  logic              finished,
    input  logic [3:0]        return_sys_func,
    input  logic [3:0]        return_state,
    output logic              done_valid,
    input  logic              done_ready,
    output logic [3:0]        done_sys_func,
    output logic [3:0]        done_state,
    output logic              done_error,
    output logic              busy
);

    logic [2:0] state;
    logic [2:0] target_sel;
    done_resp_t resp;

`ifdef DISPATCH_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] wait_count;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state          <= DISPATCH_IDLE;
            target_sel     <= MUX_TRAVERSAL;
            module_address <= '0;
            module_data    <= '0;
            resp           <= '0;
`ifdef DISPATCH_TIMEOUT_EN
            wait_count     <= '0;
`endif
        end else begin
            case (state)
                DISPATCH_IDLE: begin
                    if (req_valid) begin
                        module_address <= req_address;
                        module_data    <= req_data;
                        target_sel     <= req_sel;
                        if (is_module_sel(req_sel)) begin
                            resp  <= '0;
                            state <= DISPATCH_LAUNCH;
                        end else begin
                            // Bad target: answer immediately without touching the mux.
                            resp  <= '{sys_func: 4'h0, state: 4'h0, error: 1'b1};
                            state <= DISPATCH_RESPOND;
                        end
                    end
                end
                DISPATCH_LAUNCH: begin
                    // finished here still belongs to the previous owner of the mux.
`ifdef DISPATCH_TIMEOUT_EN
                    wait_count <= '0;
`endif
                    state <= DISPATCH_WAIT;
                end
                DISPATCH_WAIT: begin
                    if (finished) begin
                        resp  <= '{sys_func: return_sys_func, state: return_state, error: 1'b0};
                        state <= DISPATCH_RELEASE;
`ifdef DISPATCH_TIMEOUT_EN
                    end else if (wait_count == TIMEOUT_W'(TIMEOUT_CYCLES - 1)) begin
                        resp  <= '{sys_func: 4'h0, state: 4'h0, error: 1'b1};
                        state <= DISPATCH_RELEASE;
                    end else begin
                        wait_count <= wait_count + TIMEOUT_W'(1);
`endif
                    end
                end
                DISPATCH_RELEASE: begin
                    state <= DISPATCH_RESPOND;
                end
                DISPATCH_RESPOND: begin
                    if (done_ready) begin
                        state <= DISPATCH_IDLE;
                    end
                end
                default: begin
                    state <= DISPATCH_IDLE;
                end
            endcase
        end
    end

    // The mux belongs to the target only while it is being started and awaited.
    assign sel          = (state == DISPATCH_LAUNCH || state == DISPATCH_WAIT) ? target_sel : MUX_TRAVERSAL;
    assign module_start = (state == DISPATCH_LAUNCH);
    assign req_ready    = (state == DISPATCH_IDLE);
    assign busy         = (state != DISPATCH_IDLE);
    assign done_valid   = (state == DISPATCH_RESPOND);
    assign done_sys_func = resp.sys_func;
    assign done_state    = resp.state;
    assign done_error    = resp.error;

endmodule
